// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester, multiplier and result signals of the shared multiplier arbiter
interface mul_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      mul_ce;
  logic [DATA_W-1:0]         mul_din0;
  logic [DATA_W-1:0]         mul_din1;
  logic [DATA_W-1:0]         mul_dout;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic [DATA_W-1:0]         res_data;
  logic [31:0]               issue_cnt;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, mul_dout, res_ready,
    output req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_data, issue_cnt
  );

  // Requesters, multiplier and result consumer side
  modport master (
    output req_valid, req_a, req_b, mul_dout, res_ready,
    input  req_ready, mul_ce, mul_din0, mul_din1, res_valid, res_id, res_data, issue_cnt
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin time-sharing of one pipelined multiplier with tagged results
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  mul_share_arbiter_if.slave bus
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic               stall;
  logic               transfer;
  logic [MUL_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [MUL_LAT];
  logic [31:0]        cnt;
  logic [DATA_W-1:0]  din0;
  logic [DATA_W-1:0]  din1;

  // A result waiting on the consumer freezes the whole pipe, multiplier included
  assign stall    = tag_valid[MUL_LAT-1] & ~bus.res_ready;
  assign transfer = grant_any & ~stall;

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sum       = '0;
    idx       = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_id   = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Steer the granted operand pair to the multiplier; zero when nobody is granted
  always_comb begin
    din0 = '0;
    din1 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        din0 = bus.req_a[i*DATA_W +: DATA_W];
        din1 = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = grant & {NUM_REQ{~stall}};
  assign bus.mul_ce    = ~stall;
  assign bus.mul_din0  = din0;
  assign bus.mul_din1  = din1;
  assign bus.res_valid = tag_valid[MUL_LAT-1];
  assign bus.res_id    = tag_id[MUL_LAT-1];
  assign bus.res_data  = bus.mul_dout;
  assign bus.issue_cnt = cnt;

  // Pointer moves past the winner and the issue counter steps only on an accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (transfer) begin
      ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
      cnt <= cnt + 32'd1;
    end
  end

  // Tag pipeline shadows the multiplier stages so each product leaves with its owner id
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid <= '0;
    end else if (!stall) begin
      tag_valid[0] <= transfer;
      tag_id[0]    <= grant_id;
      for (int s = 1; s < MUL_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - self-checking bench for mul_share_arbiter with a scoreboard reference model
module tb_mul_share_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } res_t;

  logic clk;
  logic reset;
  logic [31:0] mul_q;

  int n_cmp;
  int n_err;

  // Reference model state
  res_t        q[$];
  int          mptr;
  logic [31:0] mcnt;
  logic [31:0] av [4];
  logic [31:0] bv [4];
  logic        exp_any;
  int          exp_gid;
  logic        exp_rv;
  logic        exp_stall;
  logic        cur_rr;
  logic        cur_rst;
  logic [31:0] held_data;
  logic [1:0]  held_id;

  mul_share_arbiter_if #(.NUM_REQ(4), .ID_W(2), .DATA_W(32)) bus ();

  mul_share_arbiter #(.NUM_REQ(4), .ID_W(2), .DATA_W(32), .MUL_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-stage ce-gated multiplier standing in for the shared instance
  always @(posedge clk) begin
    if (bus.mul_ce) mul_q <= 32'($signed(bus.mul_din0) * $signed(bus.mul_din1));
  end
  assign bus.mul_dout = mul_q;

  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] full;
    full = 64'($signed(a)) * 64'($signed(b));
    return full[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs at the falling edge and compare the combinational response with the model
  task automatic drive(input logic [3:0] v, input logic rr, input logic rst);
    logic [3:0]  exp_ready;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
    bus.req_valid = v;
    bus.res_ready = rr;
    bus.req_a     = {av[3], av[2], av[1], av[0]};
    bus.req_b     = {bv[3], bv[2], bv[1], bv[0]};
    reset         = rst;
    cur_rr        = rr;
    cur_rst       = rst;
    #1;
    exp_rv    = (q.size() != 0);
    exp_stall = exp_rv && !rr;
    exp_any   = 1'b0;
    exp_gid   = 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (mptr + k) % 4;
      if (!exp_any && v[i]) begin
        exp_any = 1'b1;
        exp_gid = i;
      end
    end
    exp_ready = (exp_any && !exp_stall) ? 4'(1 << exp_gid) : 4'b0000;
    exp_d0    = exp_any ? av[exp_gid] : 32'h0;
    exp_d1    = exp_any ? bv[exp_gid] : 32'h0;
    check("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    check("mul_ce", 32'(bus.mul_ce), 32'(!exp_stall));
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("mul_din0", bus.mul_din0, exp_d0);
    check("mul_din1", bus.mul_din1, exp_d1);
    check("issue_cnt", bus.issue_cnt, mcnt);
    if (exp_rv) begin
      check("res_id", 32'(bus.res_id), 32'(q[0].id));
      check("res_data", bus.res_data, q[0].data);
    end
  endtask

  // Advance the model across one rising edge and return at the next falling edge
  task automatic tick();
    res_t r;
    @(posedge clk);
    if (cur_rst) begin
      q.delete();
      mptr = 0;
      mcnt = 32'd0;
    end else begin
      if (exp_rv && cur_rr) void'(q.pop_front());
      if (exp_any && !exp_stall) begin
        r.id   = 2'(exp_gid);
        r.data = prod(av[exp_gid], bv[exp_gid]);
        q.push_back(r);
        mptr = (exp_gid + 1) % 4;
        mcnt = mcnt + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < 4; i++) begin
      av[i] = $urandom;
      bv[i] = $urandom;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mptr  = 0;
    mcnt  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      av[i] = 32'h0;
      bv[i] = 32'h0;
    end
    reset         = 1'b1;
    bus.req_valid = 4'b0000;
    bus.res_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    cur_rr        = 1'b1;
    cur_rst       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    drive(4'b0000, 1'b1, 1'b0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_mul_ce", 32'(bus.mul_ce), 32'd1);
    check("rst_issue_cnt", bus.issue_cnt, 32'd0);
    tick();

    // Single request from requester 2: 7 * -3
    av[2] = 32'd7;
    bv[2] = 32'hFFFF_FFFD;
    drive(4'b0100, 1'b1, 1'b0);
    check("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    check("single_valid", 32'(bus.res_valid), 32'd1);
    check("single_id", 32'(bus.res_id), 32'd2);
    check("single_data", bus.res_data, 32'hFFFF_FFEB);
    check("single_cnt", bus.issue_cnt, 32'd1);
    tick();

    // Fairness: pointer now sits at 3 with only requesters 0 and 1 valid
    randomize_ops();
    drive(4'b0011, 1'b1, 1'b0);
    check("fair_g0", 32'(bus.req_ready), 32'h1);
    tick();
    drive(4'b0011, 1'b1, 1'b0);
    check("fair_g1", 32'(bus.req_ready), 32'h2);
    tick();
    drive(4'b0011, 1'b1, 1'b0);
    check("fair_g0b", 32'(bus.req_ready), 32'h1);
    tick();
    drive(4'b1011, 1'b1, 1'b0);
    check("fair_g1b", 32'(bus.req_ready), 32'h2);
    tick();
    drive(4'b1011, 1'b1, 1'b0);
    check("fair_g3", 32'(bus.req_ready), 32'h8);
    tick();

    // All requesters valid, consumer always ready
    for (int c = 0; c < 8; c++) begin
      randomize_ops();
      drive(4'b1111, 1'b1, 1'b0);
      tick();
    end

    // Backpressure for three cycles with a result waiting
    drive(4'b1111, 1'b0, 1'b0);
    held_data = bus.res_data;
    held_id   = bus.res_id;
    check("bp_ce", 32'(bus.mul_ce), 32'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      randomize_ops();
      drive(4'b1111, 1'b0, 1'b0);
      check("bp_hold_data", bus.res_data, held_data);
      check("bp_hold_id", 32'(bus.res_id), 32'(held_id));
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    drive(4'b1111, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    tick();

    // Overflow wraps without saturation
    av[0] = 32'h7FFF_FFFF;
    bv[0] = 32'd2;
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    check("ovf_pos", bus.res_data, 32'hFFFF_FFFE);
    tick();
    av[0] = 32'h8000_0000;
    bv[0] = 32'hFFFF_FFFF;
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    check("ovf_neg", bus.res_data, 32'h8000_0000);
    tick();

    // Reset while a result is stalled
    randomize_ops();
    drive(4'b1111, 1'b1, 1'b0);
    tick();
    drive(4'b1111, 1'b0, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    drive(4'b0110, 1'b1, 1'b0);
    check("rst_mid_valid", 32'(bus.res_valid), 32'd0);
    check("rst_mid_cnt", bus.issue_cnt, 32'd0);
    check("rst_mid_grant", 32'(bus.req_ready), 32'h2);
    tick();

    // Randomized traffic with random consumer backpressure
    for (int c = 0; c < 400; c++) begin
      randomize_ops();
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that time-shares one pipelined 32x32 signed multiplier (registered output, `ce`-gated) between `NUM_REQ` pixel-pipeline requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block selects one requester per cycle and drives the multiplier's `din0`/`din1`/`ce`.
- It tracks the requester ID of every in-flight product and returns results on a single tagged result port with backpressure.
- It sits between the image-processing kernels (filter taps, scaling) and the shared multiplier instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: width of the result tag; must satisfy 2^ID_W >= NUM_REQ.
- `DATA_W`, 32: operand and product width.
- `MUL_LAT`, 1: multiplier latency in `ce`-enabled cycles, 1..4.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester operand valid.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit high.
- `req_a` in NUM_REQ*DATA_W: packed operand A, requester i at bits [i*DATA_W +: DATA_W].
- `req_b` in NUM_REQ*DATA_W: packed operand B, same packing.
- `mul_ce` out 1: multiplier clock enable.
- `mul_din0` out DATA_W: multiplier operand 0.
- `mul_din1` out DATA_W: multiplier operand 1.
- `mul_dout` in DATA_W: multiplier product, low DATA_W bits of the signed product.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumer accept.
- `res_id` out ID_W: index of the requester that owns `res_data`.
- `res_data` out DATA_W: product; equals `mul_dout`.
- `issue_cnt` out 32: count of accepted requests since reset, wraps at 2^32.

## Operation
Stall:
- `stall = res_valid & ~res_ready`.
- `mul_ce = ~stall`.
- While stalled, nothing advances: the multiplier register holds, the tag pipeline holds, and the round-robin pointer holds.

Arbitration:
- A round-robin pointer `ptr` (0..NUM_REQ-1) is set to 0 on reset.
- The grant goes to the first requester i with `req_valid[i]=1`, searching i = ptr, ptr+1, ... modulo NUM_REQ.
- Grant is combinational from the current `req_valid` and `ptr`.

Handshake:
- `req_ready[i] = grant[i] & ~stall`.
- A transfer completes when `req_valid[i] & req_ready[i]` in the same cycle.
- On a transfer, `ptr` moves to (i+1) mod NUM_REQ.
- If no requester is valid, `ptr` is unchanged.

Operand steering:
- `mul_din0`/`mul_din1` = `req_a`/`req_b` slice of the granted requester.
- With no grant, both are 0.
- Operands are driven even when stalled, but they are not captured because `mul_ce=0`.

Tag pipeline:
- MUL_LAT stages of {valid, id}, advancing only when `mul_ce=1`.
- Stage 0 loads {transfer, granted id}.
- `res_valid`/`res_id` come from the last stage, aligned with `mul_dout`.

Arithmetic:
- Product is two's-complement, truncated to DATA_W bits.
- Overflow wraps; no saturation and no flag.

Counter:
- `issue_cnt` increments by 1 on each transfer.

Reset:
- All tag valids clear, `ptr`=0, `issue_cnt`=0.
- In-flight products are discarded, including products held by a stall.
- Reset values: `res_valid`=0, `mul_ce`=1, `req_ready`=0 unless a requester is valid.

## Timing
- Throughput: one accepted request per cycle when `res_ready` stays high.
- Latency: a request accepted in cycle N shows `res_valid`=1 in cycle N+MUL_LAT, counting only unstalled cycles.
- Result port: `res_data`/`res_id` stay stable while `res_valid & ~res_ready`.
- A result is consumed on `res_valid & res_ready`; in that same cycle a new request may be accepted.
- Simultaneous acceptance at the head and completion at the tail is lossless; there are no bubbles.
- Dependencies: no combinational path from `res_ready` to `res_data`. `req_ready` depends combinationally on `req_valid`, `res_valid` and `res_ready`.

## Test plan
- **Single request, MUL_LAT=1.** Requester 2 sends a=7, b=-3 at cycle 5 → `req_ready[2]`=1 at cycle 5; `res_valid`=1, `res_id`=2, `res_data`=0xFFFFFFEB at cycle 6; `issue_cnt`=1.
- **All valid continuously, `res_ready`=1.** `req_valid`=4'b1111 → grants in order 0,1,2,3,0,... one per cycle; results return in the same ID order, back to back.
- **Backpressure.** Hold `res_ready`=0 for 3 cycles while a result is valid → `mul_ce`=0 and `req_ready`=0 throughout; `res_data`/`res_id` unchanged; no result lost or duplicated; the stream resumes on release.
- **Fairness with sparse requests.** ptr=3, `req_valid`=4'b0011 → grant to 0, then 1, then 0. Requester 3 raises valid → it is served within NUM_REQ transfers.
- **Overflow.** a=0x7FFFFFFF, b=2 → `res_data`=0xFFFFFFFE. a=0x80000000, b=-1 → `res_data`=0x80000000.
- **Reset mid-operation.** Assert `reset` for 1 cycle while 1 result is stalled and 1 is in flight → `res_valid`=0 the next cycle, `issue_cnt`=0, ptr=0; the first grant after reset goes to the lowest valid index.
